// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback sources.
// Each source has a small FIFO; a round-robin arbiter drains one head per cycle.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*5-1:0]       req_addr,
  input  logic [NUM_REQ*32-1:0]      req_data,
  output logic                       rd_we,
  output logic [4:0]                 rd_addr,
  output logic [31:0]                rd_wdata,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       idle
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [4:0]    addr_mem_q [NUM_REQ][DEPTH];
  logic [4:0]    addr_mem_d [NUM_REQ][DEPTH];
  logic [31:0]   data_mem_q [NUM_REQ][DEPTH];
  logic [31:0]   data_mem_d [NUM_REQ][DEPTH];
  logic [CW-1:0] count_q  [NUM_REQ];
  logic [CW-1:0] count_d  [NUM_REQ];
  logic [PW-1:0] wr_ptr_q [NUM_REQ];
  logic [PW-1:0] wr_ptr_d [NUM_REQ];
  logic [PW-1:0] rd_ptr_q [NUM_REQ];
  logic [PW-1:0] rd_ptr_d [NUM_REQ];

  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] grant_idx_q, grant_idx_d;
  logic          rd_we_q, rd_we_d;
  logic [4:0]    rd_addr_q, rd_addr_d;
  logic [31:0]   rd_wdata_q, rd_wdata_d;

  logic               gnt_valid;
  logic [IW-1:0]      winner;
  logic [NUM_REQ-1:0] nonempty;
  logic [NUM_REQ-1:0] enq;
  logic [NUM_REQ-1:0] deq;

  // Ready comes from registered count only; x0 writes handshake but are not stored.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      nonempty[i]  = (count_q[i] != '0);
      req_ready[i] = (count_q[i] != CW'(DEPTH));
      enq[i]       = req_valid[i] && req_ready[i] && (req_addr[5*i +: 5] != 5'd0) && !flush;
    end
  end

  always_comb begin
    int idx;
    gnt_valid = 1'b0;
    winner    = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!gnt_valid && nonempty[IW'(idx)]) begin
        gnt_valid = 1'b1;
        winner    = IW'(idx);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_valid && !flush) begin
      rr_ptr_d = (winner == IW'(NUM_REQ - 1)) ? '0 : winner + IW'(1);
    end
  end

  always_comb begin
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    deq        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      deq[i] = gnt_valid && (winner == IW'(i));
      if (flush) begin
        count_d[i]  = '0;
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
      end else begin
        if (enq[i]) begin
          addr_mem_d[i][wr_ptr_q[i]] = req_addr[5*i +: 5];
          data_mem_d[i][wr_ptr_q[i]] = req_data[32*i +: 32];
          wr_ptr_d[i]                = wr_ptr_q[i] + PW'(1);
        end
        if (deq[i]) begin
          rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
        end
        case ({enq[i], deq[i]})
          2'b10:   count_d[i] = count_q[i] + CW'(1);
          2'b01:   count_d[i] = count_q[i] - CW'(1);
          default: count_d[i] = count_q[i];
        endcase
      end
    end
  end

  always_comb begin
    rd_we_d     = gnt_valid && !flush;
    rd_addr_d   = rd_addr_q;
    rd_wdata_d  = rd_wdata_q;
    grant_idx_d = grant_idx_q;
    if (rd_we_d) begin
      rd_addr_d   = addr_mem_q[winner][rd_ptr_q[winner]];
      rd_wdata_d  = data_mem_q[winner][rd_ptr_q[winner]];
      grant_idx_d = winner;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '{default: '0};
      wr_ptr_q    <= '{default: '0};
      rd_ptr_q    <= '{default: '0};
      rr_ptr_q    <= '0;
      rd_we_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_wdata_q  <= '0;
      grant_idx_q <= '0;
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rr_ptr_q    <= rr_ptr_d;
      rd_we_q     <= rd_we_d;
      rd_addr_q   <= rd_addr_d;
      rd_wdata_q  <= rd_wdata_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  // Storage needs no reset; counts and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    addr_mem_q <= addr_mem_d;
    data_mem_q <= data_mem_d;
  end

  assign rd_we     = rd_we_q;
  assign rd_addr   = rd_addr_q;
  assign rd_wdata  = rd_wdata_q;
  assign grant_idx = grant_idx_q;
  assign idle      = (nonempty == '0) && !rd_we_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: queue-based reference model compared every
// cycle, plus directed scenarios with literal expected values.
module tb_regfile_wb_arbiter;
  localparam int N = 4;
  localparam int D = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*5-1:0] req_addr;
  logic [N*32-1:0] req_data;
  logic           rd_we;
  logic [4:0]     rd_addr;
  logic [31:0]    rd_wdata;
  logic [1:0]     grant_idx;
  logic           idle;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NUM_REQ(N), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
    .grant_idx(grant_idx), .idle(idle)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per requester, plain round-robin pointer.
  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq [N][$];
  int          m_rr = 0;
  bit          m_we = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  int          m_g = 0;
  bit          m_started = 1'b0;

  always @(posedge clk) begin
    bit   rdy [N];
    bit   found;
    int   w;
    int   idx;
    ent_t e;
    for (int i = 0; i < N; i++) rdy[i] = (mq[i].size() != D);
    if (rst) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_rr = 0; m_we = 1'b0; m_addr = '0; m_data = '0; m_g = 0;
      m_started = 1'b1;
    end else begin
      found = 1'b0;
      w = 0;
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (!found && mq[idx].size() > 0) begin
          found = 1'b1;
          w = idx;
        end
      end
      if (flush) begin
        for (int i = 0; i < N; i++) mq[i].delete();
        m_we = 1'b0;
      end else begin
        if (found) begin
          e = mq[w].pop_front();
          m_we = 1'b1; m_addr = e.a; m_data = e.d; m_g = w;
          m_rr = (w + 1) % N;
        end else begin
          m_we = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
          if (req_valid[i] && rdy[i] && req_addr[5*i +: 5] != 5'd0)
            mq[i].push_back({req_addr[5*i +: 5], req_data[32*i +: 32]});
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] er;
    bit           all_empty;
    if (m_started) begin
      all_empty = 1'b1;
      for (int i = 0; i < N; i++) begin
        er[i] = (mq[i].size() != D);
        if (mq[i].size() != 0) all_empty = 1'b0;
      end
      chk("model_rd_we", 32'(rd_we), 32'(m_we));
      chk("model_rd_addr", 32'(rd_addr), 32'(m_addr));
      chk("model_rd_wdata", rd_wdata, m_data);
      chk("model_grant_idx", 32'(grant_idx), 32'(m_g));
      chk("model_req_ready", 32'(req_ready), 32'(er));
      chk("model_idle", 32'(idle), 32'(all_empty && !m_we));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    req_valid[i]       = 1'b1;
    req_addr[5*i +: 5] = a;
    req_data[32*i +: 32] = d;
  endtask

  initial begin
    int          sent [N];
    int          target [N];
    logic [N-1:0] rdy_snap;
    bit          saw_low;
    int          g1, total, cyc, first_g1, acc3;
    bit          done;

    rst = 1'b1; flush = 1'b0; clear_reqs();
    tick(); tick();
    chk("reset_rd_we", 32'(rd_we), 32'd0);
    chk("reset_rd_addr", 32'(rd_addr), 32'd0);
    chk("reset_rd_wdata", rd_wdata, 32'd0);
    chk("reset_grant_idx", 32'(grant_idx), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'hF);
    chk("reset_idle", 32'(idle), 32'd1);
    rst = 1'b0;

    // Single write, 2-cycle latency
    set_req(0, 5'd5, 32'hDEADBEEF);
    tick(); clear_reqs();
    chk("single_n1_we", 32'(rd_we), 32'd0);
    tick();
    chk("single_we", 32'(rd_we), 32'd1);
    chk("single_addr", 32'(rd_addr), 32'd5);
    chk("single_data", rd_wdata, 32'hDEADBEEF);
    chk("single_gidx", 32'(grant_idx), 32'd0);
    tick();
    chk("single_n3_we", 32'(rd_we), 32'd0);
    chk("single_n3_idle", 32'(idle), 32'd1);

    // x0 write is swallowed
    set_req(2, 5'd0, 32'h1234);
    chk("x0_ready_pre", 32'(req_ready[2]), 32'd1);
    tick(); clear_reqs();
    chk("x0_ready_post", 32'(req_ready[2]), 32'd1);
    repeat (3) begin
      tick();
      chk("x0_rd_we", 32'(rd_we), 32'd0);
      chk("x0_idle", 32'(idle), 32'd1);
    end

    // Round robin over preloaded FIFOs
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 5'(i + 1), 32'hA000_0000 + 32'(i * 16));
    tick();
    for (int i = 0; i < N; i++) set_req(i, 5'(i + 1), 32'hA000_0001 + 32'(i * 16));
    tick(); clear_reqs();
    for (int k = 0; k < 8; k++) begin
      chk("rr_we", 32'(rd_we), 32'd1);
      chk("rr_gidx", 32'(grant_idx), 32'(k % 4));
      chk("rr_addr", 32'(rd_addr), 32'((k % 4) + 1));
      chk("rr_data", rd_wdata, 32'hA000_0000 + 32'((k % 4) * 16 + k / 4));
      tick();
    end
    chk("rr_end_we", 32'(rd_we), 32'd0);

    // Backpressure on requester 1 while others stay busy
    target = '{6, 3, 6, 6};
    for (int i = 0; i < N; i++) sent[i] = 0;
    saw_low = 1'b0; g1 = 0; total = 0; cyc = 0; first_g1 = -1; acc3 = -1;
    done = 1'b0;
    while (!done && cyc < 100) begin
      for (int i = 0; i < N; i++) begin
        if (sent[i] < target[i]) set_req(i, 5'(i + 1), 32'hB000_0000 + 32'(i * 256 + sent[i]));
        else req_valid[i] = 1'b0;
      end
      rdy_snap = req_ready;
      if (!req_ready[1] && sent[1] < target[1]) saw_low = 1'b1;
      tick(); cyc++;
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && rdy_snap[i]) begin
          sent[i]++;
          if (i == 1 && sent[i] == 3) acc3 = cyc;
        end
      end
      if (rd_we) total++;
      if (rd_we && grant_idx == 2'd1) begin
        g1++;
        if (first_g1 < 0) first_g1 = cyc;
      end
      done = idle;
      for (int i = 0; i < N; i++) if (sent[i] < target[i]) done = 1'b0;
    end
    clear_reqs();
    chk("bp_timeout", 32'(cyc < 100), 32'd1);
    chk("bp_ready1_low", 32'(saw_low), 32'd1);
    chk("bp_grants_to_1", 32'(g1), 32'd3);
    chk("bp_total_grants", 32'(total), 32'd21);
    chk("bp_third_after_grant", 32'(first_g1 >= 0 && acc3 > first_g1), 32'd1);

    // Flush drops queued writes and the concurrent enqueue
    set_req(0, 5'd3, 32'hC000_0000);
    set_req(1, 5'd4, 32'hC000_0001);
    set_req(2, 5'd6, 32'hC000_0002);
    tick(); clear_reqs();
    flush = 1'b1;
    set_req(3, 5'd9, 32'hC000_0003);
    tick(); flush = 1'b0; clear_reqs();
    chk("flush_we", 32'(rd_we), 32'd0);
    chk("flush_idle", 32'(idle), 32'd1);
    repeat (3) begin
      tick();
      chk("flush_after_we", 32'(rd_we), 32'd0);
    end

    // Reset mid-stream
    for (int i = 0; i < N; i++) set_req(i, 5'(10 + i), 32'hD000_0000 + 32'(i));
    tick();
    clear_reqs();
    set_req(0, 5'd20, 32'hD000_0010);
    set_req(1, 5'd21, 32'hD000_0011);
    tick(); clear_reqs();
    chk("mid_pre_we", 32'(rd_we), 32'd1);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("mid_we", 32'(rd_we), 32'd0);
    chk("mid_ready", 32'(req_ready), 32'hF);
    chk("mid_addr", 32'(rd_addr), 32'd0);
    chk("mid_idle", 32'(idle), 32'd1);
    set_req(1, 5'd7, 32'hE000_0001);
    set_req(3, 5'd9, 32'hE000_0003);
    tick(); clear_reqs();
    chk("post_rst_n1_we", 32'(rd_we), 32'd0);
    tick();
    chk("post_rst_gidx_a", 32'(grant_idx), 32'd1);
    chk("post_rst_addr_a", 32'(rd_addr), 32'd7);
    tick();
    chk("post_rst_gidx_b", 32'(grant_idx), 32'd3);
    chk("post_rst_addr_b", 32'(rd_addr), 32'd9);
    tick();
    chk("post_rst_end_we", 32'(rd_we), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single architectural register-file write port among NUM_REQ writeback sources (ALU, MUL, DIV, LSU).
- Each source has its own DEPTH-entry FIFO with a valid/ready handshake.
- A round-robin arbiter drains one FIFO head per cycle into registered rd_we/rd_addr/rd_wdata outputs, which drive the regfile write port directly.
- Writes to x0 are accepted and discarded. A flush input empties all queues on pipeline redirect.

Parameters:
NUM_REQ, 4, number of writeback requesters (2..8)
DEPTH, 2, entries per requester FIFO (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
flush  in  1  synchronous clear of all queued writes
req_valid  in  NUM_REQ  per-requester write valid
req_ready  out  NUM_REQ  per-requester FIFO not full
req_addr  in  NUM_REQ*5  destination reg, requester i at [5i+4:5i]
req_data  in  NUM_REQ*32  write data, requester i at [32i+31:32i]
rd_we  out  1  regfile write enable (registered)
rd_addr  out  5  regfile write address (registered)
rd_wdata  out  32  regfile write data (registered)
grant_idx  out  $clog2(NUM_REQ)  requester that produced the current rd_* write (registered)
idle  out  1  all FIFOs empty and rd_we==0

Behaviour:
- Reset:
  - All FIFOs empty; rr_ptr=0.
  - rd_we=0, rd_addr=0, rd_wdata=0, grant_idx=0.
  - req_ready=all ones; idle=1.
  - Reset mid-operation discards all queued writes. No write issues in the cycle after reset.
- Handshake:
  - Transfer on requester i occurs when req_valid[i] && req_ready[i] at a clk edge.
  - req_ready[i] = (count[i] != DEPTH). It depends only on registered state; there is no combinational path from req_valid or from dequeue.
  - A full FIFO therefore shows ready=0 even in a cycle where it is being dequeued.
- x0 filter: a transfer with req_addr==0 completes the handshake but is not stored and never produces rd_we.
- Ordering:
  - Per-requester FIFO order is preserved.
  - No ordering is guaranteed across requesters. Issue logic must not have the same rd in flight from two requesters at once.
- Arbitration (combinational, each cycle):
  - Candidates are the non-empty FIFOs.
  - Winner = first candidate scanning i = rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - On a grant, the winner's head is dequeued at the clk edge and rr_ptr <= (winner+1) mod NUM_REQ.
  - With no candidates, rr_ptr holds.
- Output register:
  - On a grant: rd_we<=1, rd_addr<=head addr, rd_wdata<=head data, grant_idx<=winner.
  - Otherwise rd_we<=0, and rd_addr/rd_wdata/grant_idx hold.
- Latency: a write accepted at edge N is arbitrated in cycle N+1 and appears on rd_* in cycle N+2 at the earliest (2 cycles minimum).
- Throughput: one regfile write per cycle while any FIFO is non-empty. Each requester sustains one write per cycle at DEPTH>=2 only when it is the sole requester.
- Fairness: with all requesters continuously non-empty, grants rotate 0,1,...,NUM_REQ-1. Worst-case wait for a head entry is NUM_REQ-1 grants.
- Simultaneous enqueue+dequeue on the same FIFO: count unchanged, pointers both advance. Pointers wrap modulo DEPTH.
- Flush (rst has priority over flush):
  - At the edge: all counts=0, pointers=0, rd_we<=0.
  - Enqueues and grants in the flush cycle are dropped.
  - rr_ptr and rd_addr/rd_wdata/grant_idx hold.
- idle = (all count==0) && !rd_we.

Test Plan:
- Single write: req 0 valid with addr=5, data=0xDEADBEEF at edge N -> rd_we=1, rd_addr=5, rd_wdata=0xDEADBEEF, grant_idx=0 in cycle N+2; rd_we=0 in N+3; idle=1 in N+3.
- x0 drop: req 2 writes addr=0, data=0x1234 -> req_ready stays 1, rd_we never asserts, idle remains 1.
- Round-robin: preload all 4 FIFOs with 2 entries each (addr=i+1) -> 8 consecutive rd_we cycles with grant_idx sequence 0,1,2,3,0,1,2,3 and in-order data per requester.
- Backpressure: hold req 1 valid with 3 writes while reqs 0, 2 and 3 keep FIFOs non-empty -> req_ready[1]=0 once count=2, the third write is accepted only after a grant to 1, and no write is lost or duplicated.
- Flush: 3 writes queued, assert flush for 1 cycle together with a new req 3 valid -> next cycle rd_we=0, idle=1, and the req 3 write never appears.
- Reset mid-stream: rst asserted while FIFOs hold 5 entries and rd_we=1 -> next cycle rd_we=0, req_ready=all ones, rd_addr=0, and a subsequent write issues with grant_idx starting at rr_ptr=0.
